// File: rtl/tsxb_fci_slave_pkg.sv
// Shared definitions for the FCI link slave: mux select codes, FSM states,
// default timing constants and the captured-cycle payload.
package tsxb_fci_slave_pkg;

  // CPLD mux select codes driven on FCI_S (code 3 mirrors ZD and is never used)
  localparam logic [1:0] FCI_ZAL = 2'd0;
  localparam logic [1:0] FCI_ZAH = 2'd1;
  localparam logic [1:0] FCI_ZD  = 2'd2;

  localparam int unsigned SETTLE_DEF = 2;
  localparam int unsigned RD_TMO_DEF = 16;
  localparam int unsigned TURN_DEF   = 1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ALO   = 4'd1,
    S_AHI   = 4'd2,
    S_DAT   = 4'd3,
    S_REQ   = 4'd4,
    S_RWAIT = 4'd5,
    S_RDRV  = 4'd6,
    S_WEND  = 4'd7,
    S_TURN  = 4'd8
  } state_t;

  // ZX cycle as gathered over the link before it is presented to the core
  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic        iorq;
  } fci_cap_t;

  // Width of a counter that must reach max(a, b)
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tsxb_fci_slave_sync2.sv
// Two-flop synchroniser for one asynchronous strobe; resets to 0.
module tsxb_fci_slave_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tsxb_fci_slave.sv
// FPGA end of the CPLD<->FPGA FCI link: walks FCI_S through ZA lo/hi/ZD for
// each ZX cycle, presents one decoded transaction and returns claimed read data.
module tsxb_fci_slave
  import tsxb_fci_slave_pkg::*;
#(
  parameter int unsigned SETTLE = SETTLE_DEF,
  parameter int unsigned RD_TMO = RD_TMO_DEF,
  parameter int unsigned TURN   = TURN_DEF
) (
  input  logic        CLK_IN,
  input  logic        RST_N,
  input  logic        FRD,
  input  logic        FWR,
  input  logic        FMRQ,
  input  logic        FIORQ,
  inout  wire  [7:0]  FCI,
  output logic [1:0]  FCI_S,
  output logic        FDIR,
  output logic        req,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  output logic        wr,
  output logic        iorq,
  input  logic        rd_hit,
  input  logic        rd_ack,
  input  logic [7:0]  rd_data
);

  localparam int unsigned CNT_W = cnt_width(SETTLE, RD_TMO);

  logic frd_s, fwr_s, fmrq_s, fiorq_s;
  logic act_c, act_d, start_c;
  logic fci_drive;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  fci_cap_t           cap;
  logic [7:0]         dout;
  logic               oe;

  tsxb_fci_slave_sync2 u_sync_rd  (.clk(CLK_IN), .rst_n(RST_N), .d(FRD),   .q(frd_s));
  tsxb_fci_slave_sync2 u_sync_wr  (.clk(CLK_IN), .rst_n(RST_N), .d(FWR),   .q(fwr_s));
  tsxb_fci_slave_sync2 u_sync_mrq (.clk(CLK_IN), .rst_n(RST_N), .d(FMRQ),  .q(fmrq_s));
  tsxb_fci_slave_sync2 u_sync_ioq (.clk(CLK_IN), .rst_n(RST_N), .d(FIORQ), .q(fiorq_s));

  // A real ZX cycle needs a qualifier and exactly one strobe (INTA has neither)
  assign act_c   = (fmrq_s | fiorq_s) & (frd_s ^ fwr_s);
  assign start_c = act_c & ~act_d;

  // Gating with act lets the pad release in the same cycle the strobe drop is seen
  assign fci_drive = oe & act_c;
  assign FCI       = fci_drive ? dout : 8'bz;

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      cnt   <= '0;
      cap   <= '0;
      dout  <= '0;
      oe    <= 1'b0;
      act_d <= 1'b0;
      FCI_S <= FCI_ZAL;
      FDIR  <= 1'b1;
      req   <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      wr    <= 1'b0;
      iorq  <= 1'b0;
    end else begin
      act_d <= act_c;
      req   <= 1'b0;
      cnt   <= cnt + CNT_W'(1);

      unique case (state)
        S_IDLE: begin
          cnt   <= '0;
          FCI_S <= FCI_ZAL;
          if (start_c) begin
            cap.wr   <= fwr_s;
            cap.iorq <= fiorq_s;
            state    <= S_ALO;
          end
        end

        S_ALO: begin
          if (!act_c) begin
            FCI_S <= FCI_ZAL;
            cnt   <= '0;
            state <= S_TURN;
          end else if (cnt == CNT_W'(SETTLE)) begin
            cap.addr[7:0] <= FCI;
            FCI_S         <= FCI_ZAH;
            cnt           <= '0;
            state         <= S_AHI;
          end
        end

        S_AHI: begin
          if (!act_c) begin
            FCI_S <= FCI_ZAL;
            cnt   <= '0;
            state <= S_TURN;
          end else if (cnt == CNT_W'(SETTLE)) begin
            cap.addr[15:8] <= FCI;
            cnt            <= '0;
            if (cap.wr) begin
              FCI_S <= FCI_ZD;
              state <= S_DAT;
            end else begin
              // Reads need no data phase: publish the transaction now
              FCI_S <= FCI_ZAL;
              addr  <= {FCI, cap.addr[7:0]};
              wr    <= 1'b0;
              iorq  <= cap.iorq;
              req   <= 1'b1;
              state <= S_REQ;
            end
          end
        end

        S_DAT: begin
          if (!act_c) begin
            FCI_S <= FCI_ZAL;
            cnt   <= '0;
            state <= S_TURN;
          end else if (cnt == CNT_W'(SETTLE)) begin
            FCI_S <= FCI_ZAL;
            addr  <= cap.addr;
            wdata <= FCI;
            wr    <= 1'b1;
            iorq  <= cap.iorq;
            req   <= 1'b1;
            cnt   <= '0;
            state <= S_REQ;
          end
        end

        S_REQ: begin
          cnt <= '0;
          if (!wr && rd_hit) begin
            state <= S_RWAIT;
          end else begin
            state <= S_WEND;
          end
        end

        S_RWAIT: begin
          if (!act_c) begin
            cnt   <= '0;
            state <= S_TURN;
          end else if (rd_ack) begin
            dout  <= rd_data;
            FDIR  <= 1'b0;
            state <= S_RDRV;
          end else if (cnt == CNT_W'(RD_TMO - 1)) begin
            state <= S_WEND;
          end
        end

        // FDIR went low on entry; the output enable follows one cycle later
        S_RDRV: begin
          if (!act_c) begin
            oe    <= 1'b0;
            state <= S_WEND;
          end else begin
            oe <= 1'b1;
          end
        end

        S_WEND: begin
          if (!act_c) begin
            oe    <= 1'b0;
            FDIR  <= 1'b1;
            cnt   <= '0;
            state <= S_TURN;
          end
        end

        S_TURN: begin
          if (cnt == CNT_W'(TURN - 1)) begin
            state <= S_IDLE;
          end
        end

        default: begin
          oe    <= 1'b0;
          FDIR  <= 1'b1;
          FCI_S <= FCI_ZAL;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
